// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller feeding an external 8-bit ALU: fetches two
// operands from a 4x8 register file, drives the ALU, captures and writes back the result.
module alu_exec_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [8:0]        instr,
    input  logic              host_we,
    input  logic [1:0]        host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] parmA,
    output logic [DATA_W-1:0] parmB,
    output logic [2:0]        selOp,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic [DATA_W-1:0] result_out,
    output logic              zero,
    output logic              illegal
);

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned OP_W   = 3;
    localparam logic [OP_W-1:0] OP_LAST_LEGAL = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic              accept;
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] ra_q;
    logic [ADDR_W-1:0] rb_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] capture;
    logic              op_illegal;
    logic [DATA_W-1:0] regs [NREGS];

    assign op_illegal = (op_q > OP_LAST_LEGAL);
    // Illegal ops capture zero so result_out and zero agree with the held value.
    assign capture    = op_illegal ? '0 : alu_result;
    assign dbg_data   = regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept     = 1'b1;
                    state_next = READ;
                end
            end
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Instruction latch, operand fetch, result capture and writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            rd_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            hold_q     <= '0;
            parmA      <= '0;
            parmB      <= '0;
            selOp      <= '0;
            result_out <= '0;
            zero       <= 1'b0;
            illegal    <= 1'b0;
            done       <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (state == IDLE && host_we) begin
                regs[host_addr] <= host_data;
            end
            if (accept) begin
                op_q <= instr[8:6];
                rd_q <= instr[5:4];
                ra_q <= instr[3:2];
                rb_q <= instr[1:0];
            end
            case (state)
                READ: begin
                    parmA <= regs[ra_q];
                    parmB <= regs[rb_q];
                    selOp <= op_q;
                end
                EXEC: begin
                    // Status is published on entry to WB so it lines up with done.
                    hold_q     <= capture;
                    result_out <= capture;
                    zero       <= (capture == '0);
                    illegal    <= op_illegal;
                    done       <= 1'b1;
                end
                WB: begin
                    if (!op_illegal) begin
                        regs[rd_q] <= hold_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural ALU closing the loop.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [8:0] instr;
    logic       host_we;
    logic [1:0] host_addr;
    logic [7:0] host_data;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
    logic [7:0] parmA;
    logic [7:0] parmB;
    logic [2:0] selOp;
    logic [7:0] alu_result;
    logic       done;
    logic [7:0] result_out;
    logic       zero;
    logic       illegal;

    int tests = 0;
    int fails = 0;
    int lat;

    alu_exec_ctrl dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .parmA(parmA), .parmB(parmB), .selOp(selOp),
        .alu_result(alu_result),
        .done(done), .result_out(result_out), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // ALU: add, sub, and, or, xor; undefined ops return a nonzero pattern.
    always_comb begin
        case (selOp)
            3'b000:  alu_result = parmA + parmB;
            3'b001:  alu_result = parmA - parmB;
            3'b010:  alu_result = parmA & parmB;
            3'b011:  alu_result = parmA | parmB;
            3'b100:  alu_result = parmA ^ parmB;
            default: alu_result = 8'hA5;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, 16'(dbg_data), 16'(exp));
    endtask

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        host_we   = 1'b1;
        host_addr = a;
        host_data = d;
        @(posedge clk);
        @(negedge clk);
        host_we = 1'b0;
    endtask

    // Presents one instruction in IDLE; returns at the negedge of cycle 1 (READ).
    task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb);
        instr_valid = 1'b1;
        instr       = {op, rd, ra, rb};
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // Called at cycle-1 negedge; returns the cycle index at which done is seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        host_we = 1'b0; host_addr = '0; host_data = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_ready", 16'(instr_ready), 16'd1);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_parmA", 16'(parmA), 16'h00);
        chk("rst_result", 16'(result_out), 16'h00);
        chk("rst_zero", 16'(zero), 16'd0);
        chk("rst_illegal", 16'(illegal), 16'd0);
        chk_reg("rst_r3", 2'd3, 8'h00);

        // ADD r0 = r1 + r2
        preload(2'd1, 8'h3C);
        preload(2'd2, 8'h0F);
        send(3'b000, 2'd0, 2'd1, 2'd2);
        chk("add_ready_read", 16'(instr_ready), 16'd0);
        @(negedge clk);
        chk("add_parmA", 16'(parmA), 16'h3C);
        chk("add_parmB", 16'(parmB), 16'h0F);
        chk("add_selOp", 16'(selOp), 16'h0);
        chk("add_done_early", 16'(done), 16'd0);
        @(negedge clk);
        chk("add_done", 16'(done), 16'd1);
        chk("add_result", 16'(result_out), 16'h4B);
        chk("add_zero", 16'(zero), 16'd0);
        @(negedge clk);
        chk("add_done_pulse", 16'(done), 16'd0);
        chk("add_ready_idle", 16'(instr_ready), 16'd1);
        chk("add_result_hold", 16'(result_out), 16'h4B);
        chk("add_parmA_hold", 16'(parmA), 16'h3C);
        chk_reg("add_r0", 2'd0, 8'h4B);

        // SUB r3 = r2 - r1, wraps
        send(3'b001, 2'd3, 2'd2, 2'd1);
        wait_done(lat);
        chk("sub_latency", 16'(lat), 16'd3);
        chk("sub_result", 16'(result_out), 16'hD3);
        chk("sub_zero", 16'(zero), 16'd0);
        chk("sub_illegal", 16'(illegal), 16'd0);
        @(negedge clk);
        chk_reg("sub_r3", 2'd3, 8'hD3);

        // XOR r1 = r1 ^ r1 -> zero
        send(3'b100, 2'd1, 2'd1, 2'd1);
        wait_done(lat);
        chk("xor_latency", 16'(lat), 16'd3);
        chk("xor_result", 16'(result_out), 16'h00);
        chk("xor_zero", 16'(zero), 16'd1);
        @(negedge clk);
        chk("xor_done_pulse", 16'(done), 16'd0);
        chk_reg("xor_r1", 2'd1, 8'h00);

        // Illegal op 110 targeting r2
        send(3'b110, 2'd2, 2'd0, 2'd0);
        wait_done(lat);
        chk("ill_latency", 16'(lat), 16'd3);
        chk("ill_flag", 16'(illegal), 16'd1);
        chk("ill_result", 16'(result_out), 16'h00);
        chk("ill_zero", 16'(zero), 16'd1);
        @(negedge clk);
        chk_reg("ill_r2", 2'd2, 8'h0F);

        // Back-to-back dependent pair with instr_valid held high
        preload(2'd1, 8'h3C);
        instr_valid = 1'b1;
        instr       = {3'b000, 2'd0, 2'd1, 2'd2};
        chk("b2b_ready_c0", 16'(instr_ready), 16'd1);
        @(posedge clk);
        @(negedge clk);
        instr = {3'b010, 2'd0, 2'd0, 2'd2};
        chk("b2b_ready_c1", 16'(instr_ready), 16'd0);
        @(negedge clk);
        chk("b2b_ready_c2", 16'(instr_ready), 16'd0);
        host_we = 1'b1; host_addr = 2'd2; host_data = 8'hFF;
        @(negedge clk);
        host_we = 1'b0;
        chk("b2b_ready_c3", 16'(instr_ready), 16'd0);
        chk("b2b_done1", 16'(done), 16'd1);
        chk("b2b_result1", 16'(result_out), 16'h4B);
        @(negedge clk);
        chk("b2b_ready_c4", 16'(instr_ready), 16'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("b2b_accepted2", 16'(instr_ready), 16'd0);
        wait_done(lat);
        chk("b2b_latency2", 16'(lat), 16'd3);
        chk("b2b_result2", 16'(result_out), 16'h0B);
        @(negedge clk);
        chk_reg("b2b_r0", 2'd0, 8'h0B);
        chk_reg("b2b_r2_kept", 2'd2, 8'h0F);

        // Reset during EXEC of an ADD
        send(3'b000, 2'd0, 2'd1, 2'd2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_done", 16'(done), 16'd0);
        chk("mrst_ready", 16'(instr_ready), 16'd1);
        chk("mrst_parmA", 16'(parmA), 16'h00);
        chk_reg("mrst_r0", 2'd0, 8'h00);
        chk_reg("mrst_r1", 2'd1, 8'h00);
        chk_reg("mrst_r2", 2'd2, 8'h00);
        @(negedge clk);
        chk("mrst_done_later", 16'(done), 16'd0);

        // Normal operation resumes
        preload(2'd1, 8'h05);
        preload(2'd2, 8'h03);
        send(3'b000, 2'd3, 2'd1, 2'd2);
        wait_done(lat);
        chk("post_latency", 16'(lat), 16'd3);
        chk("post_result", 16'(result_out), 16'h08);
        @(negedge clk);
        chk_reg("post_r3", 2'd3, 8'h08);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Multi-cycle execute controller sitting directly upstream of the 8-bit ALU. It feeds the ALU's operand and operation inputs and consumes its result.
- Accepts one register-register instruction at a time over a valid/ready handshake and reads two operands from an internal 4x8 register file.
- Drives parmA, parmB and selOp to the ALU, captures the ALU result, writes it back, and reports completion with flags.

Parameters:
- DATA_W, 8, operand/result width; must match ALU width.
- NREGS, 4, register file depth; the address width is 2 and is fixed at this depth.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  controller can accept an instruction
- instr  in  9  [8:6] op, [5:4] rd, [3:2] ra, [1:0] rb
- host_we  in  1  register preload write enable
- host_addr  in  2  preload address
- host_data  in  8  preload data
- dbg_addr  in  2  debug read address
- dbg_data  out  8  combinational read of regfile[dbg_addr]
- parmA  out  8  operand A to ALU (registered)
- parmB  out  8  operand B to ALU (registered)
- selOp  out  3  ALU operation select (registered)
- alu_result  in  8  combinational result from ALU
- done  out  1  one-cycle pulse at writeback
- result_out  out  8  last captured result, held until next done
- zero  out  1  result_out == 0, updated with done
- illegal  out  1  last instruction had op 101..111, updated with done

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - All 4 registers, parmA, parmB, selOp, result_out, zero, illegal and done go to 0.
  - instr_ready=1 in the first cycle after reset.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE. There are no other transitions except reset, which returns to IDLE from any state.
- IDLE:
  - instr_ready=1, combinationally and only in IDLE.
  - On instr_valid & instr_ready: latch op/rd/ra/rb, go to READ.
  - instr_valid without ready is ignored; the source must hold it.
- READ: parmA<=reg[ra], parmB<=reg[rb], selOp<=op; go to EXEC.
- EXEC: ALU settles combinationally; capture alu_result into an internal holding register; go to WB.
- WB:
  - If op<=100: reg[rd]<=captured result.
  - If op>=101: no write, illegal<=1.
  - In both cases: result_out<=captured result (0 for illegal), zero<=(captured==0), done=1 for exactly this cycle.
  - Go to IDLE.
- Latency: accept edge at cycle 0, done high in cycle 3. Maximum throughput is one instruction per 4 cycles; the next accept is possible in the cycle after WB.
- parmA, parmB and selOp hold their values after WB until the next READ.
- Host preload:
  - host_we is honoured only while state==IDLE; it is ignored in all other states.
  - If host_we and an accept occur in the same IDLE cycle, the preload write still happens. READ occurs the next cycle and so sees the new value.
- Same-register cases:
  - ra==rb and rd==ra are legal.
  - READ uses pre-instruction values; WB overwrites.
  - Back-to-back dependent instructions see the written value, because WB precedes the next READ.
- Arithmetic wraps modulo 256 in the ALU. The controller performs no width extension and no carry tracking.
- Reset mid-operation (READ/EXEC/WB): instruction aborted, no writeback, no done, register file cleared.

Test Plan:
- Preload r1=0x3C, r2=0x0F via host_we; instr op=000 rd=0 ra=1 rb=2 -> parmA=0x3C, parmB=0x0F, selOp=000 in EXEC; done in cycle 3; result_out=0x4B; dbg r0=0x4B; zero=0.
- Same preload; op=001 rd=3 ra=2 rb=1 -> r3=0xD3 (wrap); zero=0; illegal=0.
- op=100 rd=1 ra=1 rb=1 with r1=0x3C -> r1=0x00, zero=1, done one cycle only.
- op=110 rd=2 -> done pulses, illegal=1, result_out=0x00, r2 unchanged (0x0F).
- instr_valid held high with two dependent instructions (r0=r1+r2, then r0=r0&r2) -> instr_ready high only in IDLE; second accepted exactly 4 cycles after the first; final r0=0x0B. host_we asserted during EXEC is ignored.
- Assert rst during EXEC of an ADD to r0 -> no done; all regs 0; instr_ready=1 in the next cycle; a new instruction completes normally.
